pll_lock_rst_seq: RTL

- Reset sequencer placed directly downstream of the PLL wrapper. Runs on the free-running PLL reference clock.
- Consumes the PLL's asynchronous LOCK, drives the PLL RST input, and produces a system reset that is released only after lock has been stable.
- Detects lock loss and retries the PLL with bounded reset pulses. Flags a fault after repeated lock timeouts.
- Sits between the board oscillator/PLL and the reset synchronizers of the U3V video and audio pipelines.

---
 rtl/pll_lock_rst_seq_pkg.sv | 28 ++
 rtl/pll_lock_rst_seq_sync_bit.sv | 36 +++
 rtl/pll_lock_rst_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pll_lock_rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_seq_pkg
// Description : Shared types and helpers for the PLL lock / reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

    // Sequencer state; the numeric values are visible on state_o for debug.
    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    // Saturation value of the lock-loss counter.
    localparam logic [7:0] LOCK_CNT_SAT = 8'd255;

    // $clog2 that never returns less than 1, so single-value counters still
    // get a real bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_lock_rst_seq_sync_bit.sv
`default_nettype none
// ============================================================================
// Module      : sync_bit
// Description : N-flop single-bit synchronizer with asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the asynchronous input one stage deeper each cycle.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    // Chain flops clear to 0 so the output reads "not locked" out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_lock_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_rst_seq
// Description : Holds the PLL in reset, waits for a stable lock, releases the
//               system reset, and retries / faults on lock problems.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_rst_seq
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int RETRY_MAX      = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock_i,
    output logic       pll_rst_o,
    output logic       sys_rst_o,
    output logic       ready_o,
    output logic       fault_o,
    output logic [7:0] lock_loss_cnt_o,
    output logic [2:0] state_o
);

    localparam int c_RST_W = clog2_min1(PLL_RST_CYCLES);
    localparam int c_TMO_W = clog2_min1(LOCK_TIMEOUT);
    localparam int c_STB_W = clog2_min1(STABLE_CYCLES);
    localparam int c_RTY_W = clog2_min1(RETRY_MAX + 1);

    localparam logic [c_RST_W-1:0] c_RST_LAST = c_RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_STB_W-1:0] c_STB_LAST = c_STB_W'(STABLE_CYCLES - 1);
    localparam logic [c_RTY_W-1:0] c_RTY_MAX  = c_RTY_W'(RETRY_MAX);

    logic               lock_s;
    logic [c_RTY_W-1:0] retry_inc;

    state_e             state_q,     state_d;
    logic [c_RST_W-1:0] rst_cnt_q,   rst_cnt_d;
    logic [c_TMO_W-1:0] tmo_cnt_q,   tmo_cnt_d;
    logic [c_STB_W-1:0] stb_cnt_q,   stb_cnt_d;
    logic [c_RTY_W-1:0] retry_cnt_q, retry_cnt_d;
    logic [7:0]         loss_cnt_q,  loss_cnt_d;
    logic               pll_rst_q,   pll_rst_d;
    logic               sys_rst_q,   sys_rst_d;
    logic               ready_q,     ready_d;
    logic               fault_q,     fault_d;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pll_lock_i),
        .q_o (lock_s)
    );

    assign retry_inc = retry_cnt_q + 1'b1;

    // Next-state and counter logic; each counter clears when its state exits.
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        stb_cnt_d   = stb_cnt_q;
        retry_cnt_d = retry_cnt_q;
        loss_cnt_d  = loss_cnt_q;
        unique case (state_q)
            ST_PLL_RST: begin
                if (rst_cnt_q == c_RST_LAST) begin
                    state_d   = ST_WAIT_LOCK;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock takes priority over a timeout expiring on the same cycle.
                if (lock_s) begin
                    state_d   = ST_STABILIZE;
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == c_TMO_LAST) begin
                    tmo_cnt_d   = '0;
                    retry_cnt_d = retry_inc;
                    state_d     = (retry_inc == c_RTY_MAX) ? ST_FAULT : ST_PLL_RST;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_STABILIZE: begin
                // A dropout here is a glitch reject, not a counted loss.
                if (!lock_s) begin
                    state_d   = ST_WAIT_LOCK;
                    stb_cnt_d = '0;
                end else if (stb_cnt_q == c_STB_LAST) begin
                    state_d     = ST_RUN;
                    stb_cnt_d   = '0;
                    retry_cnt_d = '0;
                end else begin
                    stb_cnt_d = stb_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d = ST_PLL_RST;
                    if (loss_cnt_q != LOCK_CNT_SAT) begin
                        loss_cnt_d = loss_cnt_q + 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_PLL_RST;
            end
        endcase
    end

    // Outputs are decoded from the next state so they switch on the same edge.
    always_comb begin
        pll_rst_d = (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
        sys_rst_d = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
        fault_d   = fault_q || (state_d == ST_FAULT);
    end

    // State, counters and registered outputs with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PLL_RST;
            rst_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            stb_cnt_q   <= '0;
            retry_cnt_q <= '0;
            loss_cnt_q  <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            stb_cnt_q   <= stb_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_rst_o       = pll_rst_q;
    assign sys_rst_o       = sys_rst_q;
    assign ready_o         = ready_q;
    assign fault_o         = fault_q;
    assign lock_loss_cnt_o = loss_cnt_q;
    assign state_o         = state_q;

endmodule
`default_nettype wire
